// File: rtl/m_axi_lite_pkg.sv
// Shared constants for the AXI4-Lite single-transaction master:
// FSM state encoding, response codes and the response timeout length.
package m_axi_lite_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WRITE = 3'd1;
  localparam state_t S_WRESP = 3'd2;
  localparam state_t S_READ  = 3'd3;
  localparam state_t S_RDATA = 3'd4;
  localparam state_t S_DRAIN = 3'd5;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  localparam int unsigned C_TIMEOUT_CYCLES = 256;
  localparam int          TIMER_W          = $clog2(C_TIMEOUT_CYCLES);

endpackage

// File: rtl/m_axi_lite_if.sv
// AXI4-Lite bus bundle: five channels, with master and slave views.
interface m_axi_lite_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/m_axi_lite_master.sv
// AXI4-Lite master: turns one user command into one AXI read or write.
// Define M_AXI_LITE_TIMEOUT_EN to bound the B/R wait and drain late responses.
module m_axi_lite_master
  import m_axi_lite_pkg::*;
#(
  parameter int P_M_AXI_DATA_WIDTH = 32,
  parameter int P_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_wr,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                          o_rsp_valid,
  output logic [P_M_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]                    o_rsp_resp,
  m_axi_lite_if.master                  m_axi
);

  state_t state;

  assign m_axi.wstrb  = '1;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

`ifdef M_AXI_LITE_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(C_TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer;
  logic               timer_expired;

  // Counts cycles spent waiting for B or R; restarts from zero on every entry.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      timer <= '0;
    end else if (state == S_WRESP || state == S_RDATA) begin
      timer <= timer + TIMER_W'(1);
    end else begin
      timer <= '0;
    end
  end

  assign timer_expired = (timer == TIMER_LAST);
`endif

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below sees the values from before this edge.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state         <= S_IDLE;
      o_cmd_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= 2'b00;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      // NOTE: default-low here, raised for exactly one cycle below.
      o_rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          o_cmd_ready <= 1'b1;
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            if (i_cmd_wr) begin
              m_axi.awaddr  <= i_cmd_addr;
              m_axi.wdata   <= i_cmd_wdata;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= S_WRITE;
            end else begin
              m_axi.araddr  <= i_cmd_addr;
              m_axi.arvalid <= 1'b1;
              state         <= S_READ;
            end
          end
        end

        // AW and W complete independently; a low valid means that side is done.
        S_WRITE: begin
          if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
          if ((!m_axi.awvalid || m_axi.awready) &&
              (!m_axi.wvalid  || m_axi.wready)) begin
            m_axi.bready <= 1'b1;
            state        <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_rdata  <= '0;
            o_rsp_resp   <= m_axi.bresp;
            o_cmd_ready  <= 1'b1;
            state        <= S_IDLE;
          end
`ifdef M_AXI_LITE_TIMEOUT_EN
          else if (timer_expired) begin
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= RESP_TIMEOUT;
            state       <= S_DRAIN;
          end
`endif
        end

        S_READ: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_rdata  <= m_axi.rdata;
            o_rsp_resp   <= m_axi.rresp;
            o_cmd_ready  <= 1'b1;
            state        <= S_IDLE;
          end
`ifdef M_AXI_LITE_TIMEOUT_EN
          else if (timer_expired) begin
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= '0;
            o_rsp_resp  <= RESP_TIMEOUT;
            state       <= S_DRAIN;
          end
`endif
        end

`ifdef M_AXI_LITE_TIMEOUT_EN
        // Swallow the late B or R beat so the slave is not left hanging.
        S_DRAIN: begin
          if ((m_axi.bready && m_axi.bvalid) || (m_axi.rready && m_axi.rvalid)) begin
            m_axi.bready <= 1'b0;
            m_axi.rready <= 1'b0;
            o_cmd_ready  <= 1'b1;
            state        <= S_IDLE;
          end
        end
`endif

        default: begin
          m_axi.bready <= 1'b0;
          m_axi.rready <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_axi_lite_master.sv
// Scoreboard bench for m_axi_lite_master: directed commands against a
// delay-programmable AXI4-Lite slave; a monitor checks every response pulse.
module tb_m_axi_lite_master;
  import m_axi_lite_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    int            cyc;
    logic          rdy;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  rsp_t sb[$];
  rsp_t mon_e;

  m_axi_lite_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  m_axi_lite_master #(
    .P_M_AXI_DATA_WIDTH(DW),
    .P_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_wr     (cmd_wr),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_wdata  (cmd_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_resp   (rsp_resp),
    .m_axi        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got a response pulse, expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_resp", {30'd0, rsp_resp}, {30'd0, mon_e.resp});
        check("rsp_cycle", cyc, mon_e.cyc);
        check("rsp_cmd_ready", {31'd0, cmd_ready}, {31'd0, mon_e.rdy});
      end
    end
  end

  // Present one command and return the cycle in which it was accepted.
  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       output int acc);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic aw_chan(input logic [AW-1:0] exp_addr, input int dly);
    int n = 0;
    bit held = 1'b1;
    while (!bus.awvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("awvalid_rise", {31'd0, bus.awvalid}, 32'd1);
    repeat (dly) begin
      @(negedge clk);
      if (!bus.awvalid || bus.awaddr !== exp_addr) held = 1'b0;
    end
    check("aw_hold", {31'd0, held}, 32'd1);
    check("awaddr", {28'd0, bus.awaddr}, {28'd0, exp_addr});
    check("awprot", {29'd0, bus.awprot}, 32'd0);
    bus.awready = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0;
    check("aw_drop", {31'd0, bus.awvalid}, 32'd0);
  endtask

  task automatic w_chan(input logic [DW-1:0] exp_data, input int dly);
    int n = 0;
    bit held = 1'b1;
    while (!bus.wvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wvalid_rise", {31'd0, bus.wvalid}, 32'd1);
    repeat (dly) begin
      @(negedge clk);
      if (!bus.wvalid || bus.wdata !== exp_data) held = 1'b0;
    end
    check("w_hold", {31'd0, held}, 32'd1);
    check("wdata", bus.wdata, exp_data);
    check("wstrb", {28'd0, bus.wstrb}, 32'hF);
    bus.wready = 1'b1;
    @(negedge clk);
    bus.wready = 1'b0;
    check("w_drop", {31'd0, bus.wvalid}, 32'd0);
  endtask

  task automatic ar_chan(input logic [AW-1:0] exp_addr, input int dly);
    int n = 0;
    bit held = 1'b1;
    while (!bus.arvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("arvalid_rise", {31'd0, bus.arvalid}, 32'd1);
    repeat (dly) begin
      @(negedge clk);
      if (!bus.arvalid || bus.araddr !== exp_addr) held = 1'b0;
    end
    check("ar_hold", {31'd0, held}, 32'd1);
    check("araddr", {28'd0, bus.araddr}, {28'd0, exp_addr});
    check("arprot", {29'd0, bus.arprot}, 32'd0);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check("ar_drop", {31'd0, bus.arvalid}, 32'd0);
  endtask

  task automatic b_chan(input int dly, input logic [1:0] resp);
    int n = 0;
    repeat (dly) @(negedge clk);
    bus.bvalid = 1'b1;
    bus.bresp  = resp;
    while (!bus.bready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bready", {31'd0, bus.bready}, 32'd1);
    @(negedge clk);
    bus.bvalid = 1'b0;
    bus.bresp  = 2'b00;
  endtask

  task automatic r_chan(input int dly, input logic [DW-1:0] data, input logic [1:0] resp);
    int n = 0;
    repeat (dly) @(negedge clk);
    bus.rvalid = 1'b1;
    bus.rdata  = data;
    bus.rresp  = resp;
    while (!bus.rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rready", {31'd0, bus.rready}, 32'd1);
    @(negedge clk);
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.rresp  = 2'b00;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] resp, input bit rst_mid);
    int acc;
    int mx;
    issue(1'b1, addr, data, acc);
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    if (!rst_mid) sb.push_back('{'0, resp, acc + 3 + mx + b_dly, 1'b1});
    fork
      aw_chan(addr, aw_dly);
      w_chan(data, w_dly);
    join
    if (rst_mid) begin
      check("bready_in_wresp", {31'd0, bus.bready}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_bready", {31'd0, bus.bready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rel_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("rel_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);
    end else begin
      b_chan(b_dly, resp);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int ar_dly, input int r_dly, input logic [1:0] resp,
                         input bit exp_timeout);
    int acc;
    issue(1'b0, addr, '0, acc);
    if (exp_timeout)
      sb.push_back('{'0, RESP_TIMEOUT, acc + 2 + ar_dly + int'(C_TIMEOUT_CYCLES), 1'b0});
    else
      sb.push_back('{data, resp, acc + 3 + ar_dly + r_dly, 1'b1});
    ar_chan(addr, ar_dly);
    r_chan(r_dly, data, resp);
    if (exp_timeout) check("cmd_ready_after_drain", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_valid   = 1'b0;
    cmd_wr      = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;

    @(negedge clk);
    @(negedge clk);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset_valids", {27'd0, bus.awvalid, bus.wvalid, bus.arvalid, rsp_valid, 1'b0}, 32'd0);
    check("reset_readies", {30'd0, bus.bready, bus.rready}, 32'd0);
    check("reset_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    check("reset_addr", {24'd0, bus.awaddr, bus.araddr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    do_write(4'h4, 32'h0000_0055, 0, 0, 0, RESP_OKAY, 1'b0);
    do_write(4'h8, 32'hDEAD_BEEF, 0, 5, 0, RESP_OKAY, 1'b0);
    do_write(4'hC, 32'h1234_5678, 3, 1, 2, RESP_OKAY, 1'b0);
    do_read (4'h0, 32'h0000_00A5, 0, 4, RESP_OKAY, 1'b0);
    do_write(4'h2, 32'h0F0F_0F0F, 0, 0, 1, RESP_SLVERR, 1'b0);
    do_read (4'h6, 32'hCAFE_F00D, 2, 0, RESP_SLVERR, 1'b0);
`ifdef M_AXI_LITE_TIMEOUT_EN
    do_read (4'h1, 32'h0000_0077, 0, 300, RESP_OKAY, 1'b1);
`else
    do_read (4'h1, 32'h0000_0077, 0, 40, RESP_OKAY, 1'b0);
`endif
    do_write(4'h3, 32'h0000_0099, 0, 0, 10, RESP_OKAY, 1'b1);
    do_write(4'h4, 32'h0000_0055, 0, 0, 0, RESP_OKAY, 1'b0);
    do_read (4'hF, 32'h8000_0001, 1, 2, RESP_OKAY, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/m_axi_lite_master.md
M_AXI_LITE_MASTER -- requirements
Module: m_axi_lite_master

Interface
REQ-001 SHALL have parameter P_M_AXI_DATA_WIDTH, default 32, AXI data width (multiple of 8).
REQ-002 SHALL have parameter P_M_AXI_ADDR_WIDTH, default 4, AXI address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 m_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 m_axi_aresetn  in  1  asynchronous active-low reset.
REQ-006 i_cmd_valid  in  1  user command valid.
REQ-007 o_cmd_ready  out  1  block idle, command accepted when valid&ready.
REQ-008 i_cmd_wr  in  1  1=write, 0=read.
REQ-009 i_cmd_addr  in  ADDR  target address.
REQ-010 i_cmd_wdata  in  DATA  write data (ignored for reads).
REQ-011 o_rsp_valid  out  1  one-cycle response pulse.
REQ-012 o_rsp_rdata  out  DATA  read data; 0 for writes.
REQ-013 o_rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout.
REQ-014 m_axi_awaddr  out  ADDR  write address.
REQ-015 m_axi_awvalid / m_axi_awready  out / in  1  AW handshake.
REQ-016 m_axi_wdata  out  DATA  write data.
REQ-017 m_axi_wstrb  out  DATA/8  tied all-ones.
REQ-018 m_axi_wvalid / m_axi_wready  out / in  1  W handshake.
REQ-019 m_axi_bresp  in  2  write response.
REQ-020 m_axi_bvalid / m_axi_bready  in / out  1  B handshake.
REQ-021 m_axi_araddr  out  ADDR  read address.
REQ-022 m_axi_arvalid / m_axi_arready  out / in  1  AR handshake.
REQ-023 m_axi_rdata  in  DATA  read data.
REQ-024 m_axi_rresp  in  2  read response.
REQ-025 m_axi_rvalid / m_axi_rready  in / out  1  R handshake.
REQ-026 m_axi_awprot, m_axi_arprot  out  3  tied 3'b000.

Function
REQ-027 FSM states SHALL be IDLE, WRITE, WRESP, READ, RDATA, DRAIN; all AXI and user outputs registered.
REQ-028 IDLE: o_cmd_ready=1; on accept, addr/data latched, next state WRITE (awvalid=wvalid=1) or READ (arvalid=1); o_cmd_ready=0 outside IDLE.
REQ-029 WRITE: awvalid and wvalid held until own handshake, each deasserted the cycle after its handshake independently; both done (same or different cycles) -> WRESP.
REQ-030 WRESP: bready=1; on bvalid latch bresp, bready=0, o_rsp_valid=1 next cycle with rdata=0, state IDLE same cycle.
REQ-031 READ: arvalid until arready -> RDATA with rready=1; on rvalid latch rdata/rresp, pulse o_rsp_valid next cycle, IDLE.
REQ-032 Valid SHALL never drop before its ready; address/data stable while valid; one outstanding transaction.
REQ-033 Latency with zero-wait slave: accept cycle N -> o_rsp_valid at N+3; o_cmd_ready high again at N+3.
REQ-034 Slave response codes passed through unmodified.

Reset
REQ-035 Reset SHALL, asynchronously at any state: state=IDLE, all valid/ready outputs 0 except o_cmd_ready=0 until first clock after deassertion, data/addr/resp outputs 0.

Configuration
REQ-036 With M_AXI_LITE_TIMEOUT_EN: counter starts on entering WRESP/RDATA; at C_TIMEOUT_CYCLES without bvalid/rvalid -> o_rsp_valid pulse, resp 2'b11, rdata 0, state DRAIN (bready/rready held 1, cmd_ready 0) until late bvalid/rvalid absorbed silently, then IDLE; AW/W/AR phases never time out.
REQ-037 Without M_AXI_LITE_TIMEOUT_EN: no counter, no DRAIN, WRESP/RDATA wait indefinitely.

Structure
REQ-038 Package m_axi_lite_pkg SHALL hold FSM state encoding, response codes (OKAY 00, SLVERR 10, TIMEOUT 11) and C_TIMEOUT_CYCLES=256; no sub-module.

Verification
REQ-039 Write addr 0x4 data 0x55, slave zero-wait, bresp 00 -> awaddr 0x4, wdata 0x00000055, wstrb 0xF, o_rsp_valid at N+3, resp 00.
REQ-040 Write, awready immediate, wready after 5 cycles -> awvalid drops after AW handshake, wvalid held 5 cycles, exactly one response pulse.
REQ-041 Read 0x0, rvalid 4 cycles after AR with rdata 0xA5, rresp 00 -> o_rsp_rdata 0x000000A5, resp 00, single pulse.
REQ-042 Write with bresp 10 -> o_rsp_resp 10, o_rsp_rdata 0.
REQ-043 TIMEOUT_EN, read, rvalid withheld 300 cycles -> pulse resp 11 at cycle 256 of RDATA; late rvalid produces no pulse; o_cmd_ready returns after it.
REQ-044 Reset asserted in WRESP -> bready, o_rsp_valid, o_cmd_ready 0 immediately; next command after release completes normally.
